// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA demosaicing convolution stages (equ_*).
package cfa_pkg;

  // Pixel and local-mean sample width.
  localparam int unsigned PIX_W = 12;

  // Gradient width; holds 5 * (2^PIX_W - 1) = 20475.
  localparam int unsigned GRAD_W = 17;

  // Unsigned pixel sample.
  typedef logic [PIX_W-1:0] pix_t;

endpackage : cfa_pkg

// File: rtl/abs_diff.sv
// Combinational unsigned absolute difference |a - b| by compare-and-subtract.
module abs_diff
  import cfa_pkg::*;
#(
  parameter int unsigned Width = PIX_W
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] d_o
);

  // Subtract the smaller operand from the larger so the result never wraps.
  always_comb begin
    d_o = '0;
    if (a_i >= b_i) begin
      d_o = a_i - b_i;
    end else begin
      d_o = b_i - a_i;
    end
  end

endmodule : abs_diff

// File: rtl/equ_7_grad.sv
// Equation 7 gradient term: registered sum of |e_i - mean_1| over five samples.
module equ_7_grad #(
  parameter int unsigned PIX_W = cfa_pkg::PIX_W,
  parameter int unsigned OUT_W = cfa_pkg::GRAD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] e1,
  input  logic [PIX_W-1:0] e2,
  input  logic [PIX_W-1:0] e3,
  input  logic [PIX_W-1:0] e4,
  input  logic [PIX_W-1:0] e5,
  input  logic [PIX_W-1:0] mean_1,
  output logic [OUT_W-1:0] grad_abs
);

  logic [PIX_W-1:0] d1, d2, d3, d4, d5;
  logic [OUT_W-1:0] sum_12, sum_34, grad_d, grad_q;

  abs_diff #(.Width(PIX_W)) u_abs_1 (.a_i(e1), .b_i(mean_1), .d_o(d1));
  abs_diff #(.Width(PIX_W)) u_abs_2 (.a_i(e2), .b_i(mean_1), .d_o(d2));
  abs_diff #(.Width(PIX_W)) u_abs_3 (.a_i(e3), .b_i(mean_1), .d_o(d3));
  abs_diff #(.Width(PIX_W)) u_abs_4 (.a_i(e4), .b_i(mean_1), .d_o(d4));
  abs_diff #(.Width(PIX_W)) u_abs_5 (.a_i(e5), .b_i(mean_1), .d_o(d5));

  // Balanced adder tree ((d1+d2)+(d3+d4))+d5; operands zero-extended first.
  always_comb begin
    sum_12 = OUT_W'(d1) + OUT_W'(d2);
    sum_34 = OUT_W'(d3) + OUT_W'(d4);
    grad_d = sum_12 + sum_34 + OUT_W'(d5);
  end

  // Output register; asynchronous reset clears it so no X ever escapes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grad_q <= '0;
    end else begin
      grad_q <= grad_d;
    end
  end

  assign grad_abs = grad_q;

endmodule : equ_7_grad

// File: tb/tb_equ_7_grad.sv
// Self-checking bench for equ_7_grad: directed corners plus random streaming.
module tb_equ_7_grad;

  logic        clk;
  logic        rst;
  logic [11:0] e1, e2, e3, e4, e5, mean_1;
  logic [16:0] grad_abs;

  int unsigned n_cmp;
  int unsigned n_err;

  equ_7_grad u_dut (
    .clk     (clk),
    .rst     (rst),
    .e1      (e1),
    .e2      (e2),
    .e3      (e3),
    .e4      (e4),
    .e5      (e5),
    .mean_1  (mean_1),
    .grad_abs(grad_abs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of absolute signed differences using plain integers.
  function automatic int ref_grad(input int a1, input int a2, input int a3, input int a4,
                                  input int a5, input int m);
    int vals[5];
    int acc;
    vals = '{a1, a2, a3, a4, a5};
    acc  = 0;
    foreach (vals[k]) begin
      acc += (vals[k] - m < 0) ? (m - vals[k]) : (vals[k] - m);
    end
    return acc;
  endfunction

  task automatic drive(input int a1, input int a2, input int a3, input int a4, input int a5,
                       input int m);
    e1     = 12'(a1);
    e2     = 12'(a2);
    e3     = 12'(a3);
    e4     = 12'(a4);
    e5     = 12'(a5);
    mean_1 = 12'(m);
  endtask

  // Drive a vector on the falling edge, check the result just after the rising edge.
  task automatic vec(input string tag, input int a1, input int a2, input int a3, input int a4,
                     input int a5, input int m, input int exp);
    @(negedge clk);
    drive(a1, a2, a3, a4, a5, m);
    @(posedge clk);
    #1;
    check(tag, 32'(grad_abs), 32'(exp));
  endtask

  initial begin
    int r[6];
    int prev;
    n_cmp = 0;
    n_err = 0;

    // Reset with non-zero inputs: output must be 0 immediately and across an edge.
    rst = 1'b0;
    drive(4095, 17, 300, 9, 2222, 1);
    #1;
    check("reset_immediate", 32'(grad_abs), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 32'(grad_abs), 32'd0);

    // Release with all-equal inputs.
    @(negedge clk);
    rst = 1'b1;
    drive(100, 100, 100, 100, 100, 100);
    @(posedge clk);
    #1;
    check("equal_after_release", 32'(grad_abs), 32'd0);

    vec("ramp", 10, 20, 30, 40, 50, 30, 60);
    // Previous result must hold until the next edge even after inputs change.
    @(negedge clk);
    drive(4095, 4095, 4095, 4095, 4095, 0);
    #1;
    check("hold_until_edge", 32'(grad_abs), 32'd60);
    @(posedge clk);
    #1;
    check("pos_extreme", 32'(grad_abs), 32'd20475);
    vec("neg_extreme", 0, 0, 0, 0, 0, 4095, 20475);
    vec("mixed_sign", 1000, 3000, 2000, 0, 4095, 2000, 6095);
    vec("equal_max", 4095, 4095, 4095, 4095, 4095, 4095, 0);
    vec("single_dev", 7, 0, 0, 0, 0, 0, 7);
    vec("one_below", 0, 1, 1, 1, 1, 1, 1);

    // Random streaming with a mid-stream asynchronous reset.
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      foreach (r[k]) r[k] = int'($urandom_range(0, 4095));
      if (i % 7 == 0) r[5] = int'($urandom_range(0, 1)) * 4095;
      drive(r[0], r[1], r[2], r[3], r[4], r[5]);
      if (i == 500) begin
        // Assert reset between edges: output clears at once, samples are discarded.
        #2;
        rst = 1'b0;
        #1;
        check("midreset_immediate", 32'(grad_abs), 32'd0);
        @(posedge clk);
        #1;
        check("midreset_discard", 32'(grad_abs), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        foreach (r[k]) r[k] = int'($urandom_range(0, 4095));
        drive(r[0], r[1], r[2], r[3], r[4], r[5]);
      end
      @(posedge clk);
      #1;
      prev = ref_grad(r[0], r[1], r[2], r[3], r[4], r[5]);
      check($sformatf("stream_%0d", i), 32'(grad_abs), 32'(prev));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule : tb_equ_7_grad
